// File: rtl/demux_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_pkg
// Purpose  : Shared channel count, select type and select decoder for the
//            1:4 stream demultiplexer.
// Revision : 1.0  initial release
// ============================================================================
package demux_stream_pkg;

    localparam int N_CH = 4;

    typedef logic [1:0] ch_sel_t;

    // One-hot decode of a channel select.
    function automatic logic [N_CH-1:0] sel_onehot(input ch_sel_t sel);
        logic [N_CH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage : demux_stream_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Purpose  : One-entry holding register for a single output channel of the
//            stream demultiplexer (accept overrides drain in the same cycle).
// Revision : 1.0  initial release
// ============================================================================
module demux_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         full,
    output logic [W-1:0] data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // The payload is never cleared on drain; it only changes on a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (wr_en) begin
            r_full <= 1'b1;
            r_data <= wr_data;
        end else if (r_full && rd_ready) begin
            r_full <= 1'b0;
        end
    end

    assign full = r_full;
    assign data = r_data;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_1_4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1_4_stream
// Purpose  : Steers a valid/ready input stream to one of four registered
//            output channels selected per beat by in_sel.
// Revision : 1.0  initial release
// ============================================================================
module demux_1_4_stream
    import demux_stream_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data0,
    output logic [W-1:0] out_data1,
    output logic [W-1:0] out_data2,
    output logic [W-1:0] out_data3
);

    logic [N_CH-1:0] w_full;
    logic [N_CH-1:0] w_wr_en;
    logic [W-1:0]    w_slot [N_CH];
    logic            w_accept;

    // Only the addressed channel gates the producer; a stalled channel never
    // holds back beats for the others.
    assign in_ready = rst_n && (!w_full[in_sel] || out_ready[in_sel]);
    assign w_accept = in_valid && in_ready;
    assign w_wr_en  = w_accept ? sel_onehot(in_sel) : '0;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_slot
            demux_slot #(
                .W (W)
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (w_wr_en[i]),
                .wr_data  (in_data),
                .rd_ready (out_ready[i]),
                .full     (w_full[i]),
                .data     (w_slot[i])
            );
        end
    endgenerate

    assign out_valid = w_full;
    assign out_data0 = w_slot[0];
    assign out_data1 = w_slot[1];
    assign out_data2 = w_slot[2];
    assign out_data3 = w_slot[3];

endmodule : demux_1_4_stream
`default_nettype wire

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
- Stream-side counterpart of the team's 4:1 data multiplexer: takes one valid/ready input stream tagged with a 2-bit destination and steers each beat to one of four output channels.
- Each output channel has a one-entry holding register, so a stall on one destination never loses data and never blocks traffic bound for a free channel.
- Sits between a single producer and four independent consumers in the same datapath family as the 4:1 mux.

Parameters:
W, 4, data width of every channel in bits (legal: W >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  producer has a beat on in_data/in_sel
in_ready  output  1  block accepts the beat this cycle
in_data  input  W  beat payload
in_sel  input  2  destination channel 0..3
out_valid  output  4  bit i: channel i holds a beat
out_ready  input  4  bit i: consumer i takes the beat this cycle
out_data0  output  W  channel 0 payload
out_data1  output  W  channel 1 payload
out_data2  output  W  channel 2 payload
out_data3  output  W  channel 3 payload

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: all slot valid flags = 0, all slot data registers = 0, so out_valid=4'b0000 and out_data0..3 = 0. in_ready is forced to 0 while rst_n=0. Reset asserted mid-transfer drops every held beat; no partial state survives.
- Per-channel state: full[i] (1 bit), slot[i] (W bits). out_valid[i] = full[i]; out_dataI = slot[i]. These are register outputs with no combinational path from inputs.
- in_ready = rst_n && (!full[in_sel] || out_ready[in_sel]). This is combinational, depends only on the selected channel, and is independent of in_valid.
- Accept: acc = in_valid && in_ready. On acc, slot[in_sel] <= in_data and full[in_sel] <= 1 at the next edge.
- Drain: drn[i] = full[i] && out_ready[i]. On drn[i] with no accept into channel i, full[i] <= 0. slot[i] holds its last value and is not cleared.
- Simultaneous drain and accept on the same channel: full stays 1 and slot takes the new beat. This gives full throughput of 1 beat/cycle per channel with the consumer always ready.
- Only the channel addressed by in_sel is written. The other three channels drain independently in the same cycle.
- Latency: a beat accepted at edge N is visible on out_valid/out_data from edge N. The output is registered, with one cycle from the in_valid&&in_ready cycle to out_valid.
- Stall: a full channel with out_ready=0 holds slot and out_valid stable indefinitely. A beat for that channel sees in_ready=0, while a beat for any other empty channel is accepted.
- Data is passed bit-exact, including X/Z bits. The block performs no arithmetic on data.
- in_sel and in_data may change while in_valid=0 or in_ready=0; only the values in the accept cycle matter.
- No beat is ever duplicated, dropped (outside reset), or delivered to a channel other than in_sel.

Decomposition:
- Package demux_stream_pkg: localparam N_CH = 4; typedef logic [1:0] ch_sel_t.
- Sub-module demux_slot (params W; ports clk, rst_n, wr_en, wr_data, rd_ready, full, data). It implements one holding register with the accept/drain rules above.
- Top decodes in_sel to a one-hot wr_en, instantiates four demux_slot, and builds in_ready.

Test Plan:
- Reset then idle -> out_valid=0000, out_data0..3=0, in_ready=0 while rst_n=0 and 1 after release.
- Beats 'ha/'hb/'hc/'hd with sel 0/1/2/3, all out_ready=1 -> one cycle later each appears on its own channel only; out_valid one-hot per beat.
- out_ready[2]=0, send 'h3 sel 2, then 'h7 sel 2, then 'h5 sel 0 -> out_data2='h3 held; in_ready=0 for the sel 2 beat; the sel 0 beat is accepted the same cycle and out_data0='h5; raising out_ready[2] releases 'h3, then 'h7 is accepted.
- Back-to-back 16 beats to sel 1 with out_ready[1]=1 -> in_ready stays 1 and the consumer sees 16 consecutive beats in order (throughput 1/cycle).
- Beat data 4'bxx01 to sel 3 -> out_data3 === 4'bxx01; other channels are unchanged.
- Fill channels 0 and 2, then assert rst_n=0 asynchronously mid-cycle -> out_valid drops to 0000 immediately, without waiting for a clock edge, and the held beats are never delivered after release.
